// File: rtl/feature_col_feeder_pkg.sv
// ---------------------------------------------------------------------------
// feature_col_feeder_pkg
// Shared network parameters for the feature column feeder: channel count,
// kernel sizes, pixel width, kernel-mode encodings and the feeder FSM state
// encoding. Imported by feature_col_feeder and col_addr_gen.
// ---------------------------------------------------------------------------
package feature_col_feeder_pkg;

    localparam int Tn            = 4;
    localparam int KERNEL_SIZE   = 5;
    localparam int KERNEL_SIZE_3 = 3;
    localparam int FEATURE_WIDTH = 16;
    localparam int ADDR_WIDTH    = 12;
    localparam int CNT_WIDTH     = 10;

    localparam logic KERNEL_SIZE_5_MODE = 1'b0;
    localparam logic KERNEL_SIZE_3_MODE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } feeder_state_t;

    // Number of columns streamed per window for a given kernel mode.
    function automatic int kernel_cols(input logic mode);
        return (mode == KERNEL_SIZE_3_MODE) ? KERNEL_SIZE_3 : KERNEL_SIZE;
    endfunction

endpackage

// File: rtl/col_addr_gen.sv
// ---------------------------------------------------------------------------
// col_addr_gen
// Window/column address bookkeeping for the feature column feeder.
// Owns the window start address, the column counter inside a window, the
// window index and (optionally) the zero-pad comparison.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   init            latch job config, clear counters (start accepted in IDLE)
//   col_step        one column read issued this cycle
//   win_step        window finished (shift_done accepted in WAIT)
//   base_addr       address of column 0 of window 0
//   win_stride      address step between windows
//   num_windows     windows in the job
//   img_width       valid column count (zero-pad build only)
//   col_addr        win_addr + col, wraps modulo 2^ADDR_WIDTH
//   col             columns issued so far in the current window
//   last_win        current window is the last one of the job
//   pad_hit         current column lies beyond img_width
//
// Build option: FEATURE_COL_FEEDER_ZERO_PAD_EN enables pad_hit; otherwise
// pad_hit is tied low and img_width is ignored.
// ---------------------------------------------------------------------------
module col_addr_gen
    import feature_col_feeder_pkg::*;
#(
    parameter int ADDR_WIDTH = feature_col_feeder_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = feature_col_feeder_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  col_step,
    input  logic                  win_step,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] win_stride,
    input  logic [CNT_WIDTH-1:0]  num_windows,
    input  logic [CNT_WIDTH-1:0]  img_width,
    output logic [ADDR_WIDTH-1:0] col_addr,
    output logic [CNT_WIDTH-1:0]  col,
    output logic                  last_win,
    output logic                  pad_hit
);

    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  nw_q;
    logic [CNT_WIDTH-1:0]  win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_addr <= '0;
            stride_q <= '0;
            nw_q     <= '0;
            win_idx  <= '0;
            col      <= '0;
        end else if (init) begin
            win_addr <= base_addr;
            stride_q <= win_stride;
            nw_q     <= num_windows;
            win_idx  <= '0;
            col      <= '0;
        end else begin
            if (col_step) begin
                col <= col + CNT_WIDTH'(1);
            end
            if (win_step) begin
                col      <= '0;
                win_idx  <= win_idx + CNT_WIDTH'(1);
                win_addr <= win_addr + stride_q;
            end
        end
    end

    assign col_addr = win_addr + ADDR_WIDTH'(col);
    assign last_win = ((win_idx + CNT_WIDTH'(1)) == nw_q);

`ifdef FEATURE_COL_FEEDER_ZERO_PAD_EN
    // Column position in image coordinates is win_idx*win_stride + col,
    // kept as a running sum wide enough that it never wraps within a job.
    localparam int POS_W = ADDR_WIDTH + CNT_WIDTH;

    logic [POS_W-1:0]     pos_base;
    logic [CNT_WIDTH-1:0] img_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_base <= '0;
            img_q    <= '0;
        end else if (init) begin
            pos_base <= '0;
            img_q    <= img_width;
        end else if (win_step) begin
            pos_base <= pos_base + POS_W'(stride_q);
        end
    end

    assign pad_hit = ((pos_base + POS_W'(col)) >= POS_W'(img_q));
`else
    logic unused_img_width;
    assign unused_img_width = ^img_width;
    assign pad_hit          = 1'b0;
`endif

endmodule

// File: rtl/feature_col_feeder.sv
// ---------------------------------------------------------------------------
// feature_col_feeder
// Upstream stage of the kernel-window vertical shift register. For each
// window it pulses enable, reads K consecutive feature columns from the
// feature buffer and streams them onto dia_0 or dia_1 (ping-pong per
// window), then waits for shift_done before moving to the next window.
//
//   state | meaning
//   IDLE  | waiting for start; empty jobs finish here with job_done
//   ISSUE | enable pulse to the shift stage, in_select already valid
//   FETCH | K column reads, rd_addr = win_addr + col
//   WAIT  | last column lands on dia; hold until shift_done
//   FIN   | job_done pulse, busy low
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         begin a job (ignored unless IDLE)
//   kn_size_mode                  0 = 5x5 (K=5), 1 = 3x3 (K=3)
//   base_addr, win_stride         window 0 address and window step
//   num_windows                   windows per job, 0 = empty job
//   img_width                     valid column count (zero-pad build only)
//   rd_en, rd_addr, rd_data       feature buffer read port
//   enable, in_select             window-start pulse and path select
//   dia_0, dia_1                  column streams, path 0 / path 1
//   shift_done                    shift stage finished current window
//   busy, job_done                job status
//
// Timing: with enable at cycle E, rd_en is high at E+1..E+K and column j
// appears on the selected dia at E+2+j. rd_data must carry the word at
// rd_addr during the rd_en cycle; the dia register supplies the one cycle
// of read latency. The other dia holds its value.
//
// Build option: FEATURE_COL_FEEDER_ZERO_PAD_EN zero-fills columns at or
// beyond img_width and suppresses their reads; timing is unchanged.
// ---------------------------------------------------------------------------
module feature_col_feeder
    import feature_col_feeder_pkg::*;
#(
    parameter int Tn            = feature_col_feeder_pkg::Tn,
    parameter int KERNEL_SIZE   = feature_col_feeder_pkg::KERNEL_SIZE,
    parameter int FEATURE_WIDTH = feature_col_feeder_pkg::FEATURE_WIDTH,
    parameter int ADDR_WIDTH    = feature_col_feeder_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH     = feature_col_feeder_pkg::CNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  kn_size_mode,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [ADDR_WIDTH-1:0]                 win_stride,
    input  logic [CNT_WIDTH-1:0]                  num_windows,
    input  logic [CNT_WIDTH-1:0]                  img_width,
    output logic                                  rd_en,
    output logic [ADDR_WIDTH-1:0]                 rd_addr,
    input  logic [Tn*KERNEL_SIZE*FEATURE_WIDTH-1:0] rd_data,
    output logic                                  enable,
    output logic                                  in_select,
    output logic [Tn*KERNEL_SIZE*FEATURE_WIDTH-1:0] dia_0,
    output logic [Tn*KERNEL_SIZE*FEATURE_WIDTH-1:0] dia_1,
    input  logic                                  shift_done,
    output logic                                  busy,
    output logic                                  job_done
);

    feeder_state_t         state;
    logic [CNT_WIDTH-1:0]  k_val;
    logic [CNT_WIDTH-1:0]  col;
    logic [ADDR_WIDTH-1:0] col_addr;
    logic                  last_win;
    logic                  pad_hit;
    logic                  fetch_more;
    logic                  slot_vld;   // a column lands in the dia register this cycle
    logic                  slot_pad;   // that column is zero-filled
    logic                  gen_init;
    logic                  gen_col_step;
    logic                  gen_win_step;

    assign fetch_more   = (col != k_val);
    assign gen_init     = (state == ST_IDLE) && start;
    assign gen_col_step = ((state == ST_ISSUE) || (state == ST_FETCH)) && fetch_more;
    assign gen_win_step = (state == ST_WAIT) && shift_done;

    col_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_col_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .init        (gen_init),
        .col_step    (gen_col_step),
        .win_step    (gen_win_step),
        .base_addr   (base_addr),
        .win_stride  (win_stride),
        .num_windows (num_windows),
        .img_width   (img_width),
        .col_addr    (col_addr),
        .col         (col),
        .last_win    (last_win),
        .pad_hit     (pad_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_val     <= '0;
            enable    <= 1'b0;
            in_select <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            job_done  <= 1'b0;
            slot_vld  <= 1'b0;
            slot_pad  <= 1'b0;
            dia_0     <= '0;
            dia_1     <= '0;
        end else begin
            enable   <= 1'b0;
            job_done <= 1'b0;
            rd_en    <= 1'b0;
            slot_vld <= 1'b0;
            slot_pad <= 1'b0;

            // in_select cannot toggle before the last column has landed,
            // so the capture always targets the window's own path.
            if (slot_vld) begin
                if (in_select) begin
                    dia_1 <= slot_pad ? '0 : rd_data;
                end else begin
                    dia_0 <= slot_pad ? '0 : rd_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_select <= 1'b0;
                        k_val     <= CNT_WIDTH'(kernel_cols(kn_size_mode));
                        if (num_windows == '0) begin
                            job_done <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            enable <= 1'b1;
                            state  <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE, ST_FETCH: begin
                    if (fetch_more) begin
                        rd_en    <= ~pad_hit;
                        rd_addr  <= col_addr;
                        slot_vld <= 1'b1;
                        slot_pad <= pad_hit;
                        state    <= ST_FETCH;
                    end else begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (shift_done) begin
                        in_select <= ~in_select;
                        if (last_win) begin
                            busy     <= 1'b0;
                            job_done <= 1'b1;
                            state    <= ST_FIN;
                        end else begin
                            enable <= 1'b1;
                            state  <= ST_ISSUE;
                        end
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_col_feeder.sv
module tb_feature_col_feeder;

    localparam int TN = 4;
    localparam int KS = 5;
    localparam int FW = 16;
    localparam int AW = 12;
    localparam int CW = 10;
    localparam int DW = TN * KS * FW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          kn_size_mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] win_stride = '0;
    logic [CW-1:0] num_windows = '0;
    logic [CW-1:0] img_width = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          enable;
    logic          in_select;
    logic [DW-1:0] dia_0;
    logic [DW-1:0] dia_1;
    logic          shift_done = 1'b0;
    logic          busy;
    logic          job_done;

    always #5 clk = ~clk;

    // Feature buffer contents: lane i of address a holds {a, i}.
    function automatic logic [DW-1:0] mem_word(input int a);
        logic [DW-1:0] w;
        logic [11:0]   a12;
        a12 = a[11:0];
        for (int i = 0; i < TN * KS; i++) w[i*FW +: FW] = {a12, 4'(i)};
        return w;
    endfunction

    assign rd_data = mem_word(int'(rd_addr));

    feature_col_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .kn_size_mode (kn_size_mode),
        .base_addr    (base_addr),
        .win_stride   (win_stride),
        .num_windows  (num_windows),
        .img_width    (img_width),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .enable       (enable),
        .in_select    (in_select),
        .dia_0        (dia_0),
        .dia_1        (dia_1),
        .shift_done   (shift_done),
        .busy         (busy),
        .job_done     (job_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic bit col_pad(input int win, input int stride, input int j, input int imgw);
        bit p;
        p = ((win * stride + j) >= imgw);
`ifdef FEATURE_COL_FEEDER_ZERO_PAD_EN
        return p;
`else
        return 1'b0 & p;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // m_t is the cycle offset from the current window's enable pulse.
    int            m_active, m_t, m_K, m_win, m_nw, m_base, m_stride, m_imgw, m_jobs;
    bit            m_sel, m_fin, fin_now;
    logic          exp_enable, exp_rd_en, exp_in_select, exp_busy, exp_job_done;
    logic [AW-1:0] exp_rd_addr;
    logic [DW-1:0] exp_dia0, exp_dia1, cap_word, prev_d0;
    int            mj;

    // observation logs for the hand-computed checks
    int            n_enable, n_rd_en, n_job_done, d0_chg, jd_cyc, sd_cyc, st_cyc;
    int            en_cyc[$];
    bit            en_sel[$];
    logic [AW-1:0] addr_q[$];
    logic [15:0]   d0l[int];

    initial begin
        m_jobs = 0;
        prev_d0 = '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 0; m_fin = 0; m_sel = 0; m_t = 0; m_win = 0;
            exp_enable = 0; exp_rd_en = 0; exp_in_select = 0; exp_busy = 0;
            exp_job_done = 0; exp_rd_addr = '0; exp_dia0 = '0; exp_dia1 = '0;
        end

        chk1("enable",    32'(enable),    32'(exp_enable));
        chk1("rd_en",     32'(rd_en),     32'(exp_rd_en));
        chk1("in_select", 32'(in_select), 32'(exp_in_select));
        chk1("busy",      32'(busy),      32'(exp_busy));
        chk1("job_done",  32'(job_done),  32'(exp_job_done));
        if (exp_rd_en || rst) chk1("rd_addr", 32'(rd_addr), 32'(exp_rd_addr));
        chkw("dia_0", dia_0, exp_dia0);
        chkw("dia_1", dia_1, exp_dia1);

        if (enable) begin n_enable++; en_cyc.push_back(cyc); en_sel.push_back(in_select); end
        if (rd_en) begin n_rd_en++; addr_q.push_back(rd_addr); end
        if (job_done) begin n_job_done++; jd_cyc = cyc; end
        if (dia_0 !== prev_d0) d0_chg++;
        prev_d0 = dia_0;
        d0l[cyc] = dia_0[15:0];

        if (!rst) begin
            fin_now = m_fin;
            m_fin   = 0;
            // column read this cycle lands on the selected path next cycle
            if (m_active != 0 && m_t >= 1 && m_t <= m_K) begin
                mj = m_t - 1;
                cap_word = col_pad(m_win, m_stride, mj, m_imgw) ? '0
                         : mem_word(m_base + m_win * m_stride + mj);
                if (m_sel) exp_dia1 = cap_word; else exp_dia0 = cap_word;
            end
            exp_enable = 0; exp_rd_en = 0; exp_job_done = 0;
            if (m_active == 0) begin
                if (start && !fin_now) begin
                    m_base = int'(base_addr); m_stride = int'(win_stride);
                    m_nw = int'(num_windows); m_imgw = int'(img_width);
                    m_K = kn_size_mode ? 3 : 5;
                    m_sel = 0; m_win = 0;
                    if (m_nw == 0) begin
                        exp_job_done = 1; m_jobs++;
                    end else begin
                        m_active = 1; m_t = 0; exp_busy = 1;
                    end
                end
            end else if (m_t <= m_K) begin
                m_t++;
            end else if (shift_done) begin
                m_win++;
                m_sel = ~m_sel;
                if (m_win == m_nw) begin
                    m_active = 0; m_fin = 1; exp_job_done = 1; exp_busy = 0; m_jobs++;
                end else begin
                    m_t = 0;
                end
            end
            if (m_active != 0) begin
                exp_enable = (m_t == 0);
                if (m_t >= 1 && m_t <= m_K) begin
                    mj = m_t - 1;
                    exp_rd_en   = !col_pad(m_win, m_stride, mj, m_imgw);
                    exp_rd_addr = AW'(m_base + m_win * m_stride + mj);
                end
            end
            exp_in_select = m_sel;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_logs();
        n_enable = 0; n_rd_en = 0; n_job_done = 0; d0_chg = 0;
        jd_cyc = -1; sd_cyc = -1;
        en_cyc.delete(); en_sel.delete(); addr_q.delete();
    endtask

    task automatic run_job(input bit mode, input int base, input int stride, input int nw,
                           input int imgw, input int delay, input bit spurious,
                           input int extra_at, input int rst_win);
        int  wc, jobs0;
        bit  done;
        jobs0 = m_jobs;
        @(posedge clk); #2;
        kn_size_mode = mode; base_addr = AW'(base); win_stride = AW'(stride);
        num_windows = CW'(nw); img_width = CW'(imgw); start = 1'b1; st_cyc = cyc + 1;
        @(posedge clk); #2;
        start = 1'b0;
        kn_size_mode = 1'($urandom); base_addr = AW'($urandom); win_stride = AW'($urandom);
        num_windows = CW'($urandom); img_width = CW'($urandom);
        wc = 0; done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (m_jobs != jobs0) begin
                done = 1;
            end else begin
                @(posedge clk); #2;
                shift_done = 1'b0;
                start = (k == extra_at);
                if (rst_win >= 0 && m_active != 0 && m_win == rst_win && m_t == 2) begin
                    rst = 1'b1;
                    @(posedge clk); #2;
                    @(posedge clk); #2;
                    rst = 1'b0;
                    done = 1;
                end else if (m_active != 0 && m_t > m_K) begin
                    if (wc >= delay) begin
                        shift_done = 1'b1; sd_cyc = cyc + 1; wc = 0;
                    end else begin
                        wc++;
                    end
                end else if (spurious && m_active != 0 && m_t == 2) begin
                    shift_done = 1'b1;
                end
            end
        end
        if (!done) begin
            fails++; tests++;
            $display("FAIL job_timeout: got no job end required job end within 3000 cycles");
        end
        @(posedge clk); #2;
        shift_done = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic d0_at(input string nm, input int c, input logic [15:0] req);
        chk1(nm, d0l.exists(c) ? 32'(d0l[c]) : 32'hdead_beef, 32'(req));
    endtask

    int expA[10] = '{'h010, 'h011, 'h012, 'h013, 'h014, 'h011, 'h012, 'h013, 'h014, 'h015};

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk1("rst_enable", 32'(enable), 0);
        chk1("rst_rd_en", 32'(rd_en), 0);
        chk1("rst_busy", 32'(busy), 0);
        chk1("rst_in_select", 32'(in_select), 0);
        chkw("rst_dia_0", dia_0, '0);
        rst = 1'b0;

        // 3x3, one window
        clr_logs();
        run_job(1'b1, 'h100, 2, 1, 1023, 1, 1'b0, -1, -1);
        chk1("B_rd_en_cycles", n_rd_en, 3);
        chk1("B_dia0_updates", d0_chg, 3);
        chkw("B_dia1_zero", dia_1, '0);
        chk1("B_job_done", n_job_done, 1);

        // 5x5, base 0x010, stride 1, two windows
        clr_logs();
        run_job(1'b0, 'h010, 1, 2, 1023, 2, 1'b0, -1, -1);
        chk1("A_enable_cnt", n_enable, 2);
        chk1("A_rd_cnt", addr_q.size(), 10);
        for (int i = 0; i < 10 && i < addr_q.size(); i++) chk1("A_rd_addr", 32'(addr_q[i]), expA[i]);
        if (en_sel.size() == 2) begin
            chk1("A_sel0", 32'(en_sel[0]), 0);
            chk1("A_sel1", 32'(en_sel[1]), 1);
            d0_at("A_dia0_col0", en_cyc[0] + 2, 16'h0100);
            d0_at("A_dia0_col4", en_cyc[0] + 6, 16'h0140);
            d0_at("A_dia0_hold", en_cyc[1] + 6, 16'h0140);
        end
        chk1("A_job_done_lat", jd_cyc - sd_cyc, 1);

        // slow shift_done with a spurious pulse during FETCH
        clr_logs();
        run_job(1'b0, 'h300, 7, 2, 1023, 20, 1'b1, -1, -1);
        chk1("C_rd_en_cycles", n_rd_en, 10);
        if (en_cyc.size() == 2) chk1("C_enable_gap", en_cyc[1] - en_cyc[0], 27);
        else chk1("C_enable_cnt", en_cyc.size(), 2);

        // empty job, then a start while busy
        clr_logs();
        run_job(1'b0, 'h050, 1, 0, 1023, 0, 1'b0, -1, -1);
        chk1("D_empty_enable", n_enable, 0);
        chk1("D_empty_rd_en", n_rd_en, 0);
        chk1("D_empty_done_lat", jd_cyc - st_cyc, 1);
        clr_logs();
        run_job(1'b0, 'h060, 3, 3, 1023, 1, 1'b0, 4, -1);
        chk1("D_busy_start_enables", n_enable, 3);
        chk1("D_busy_start_done", n_job_done, 1);

        // reset during FETCH of window 1
        clr_logs();
        run_job(1'b0, 'h400, 5, 3, 1023, 0, 1'b0, -1, 1);
        chk1("E_busy_after_rst", 32'(busy), 0);
        chkw("E_dia0_after_rst", dia_0, '0);
        repeat (30) @(posedge clk);
        #2;
        chk1("E_no_job_done", n_job_done, 0);
        clr_logs();
        run_job(1'b0, 'h410, 2, 2, 1023, 1, 1'b0, -1, -1);
        chk1("E_rerun_done", n_job_done, 1);
        chk1("E_rerun_enables", n_enable, 2);

`ifdef FEATURE_COL_FEEDER_ZERO_PAD_EN
        clr_logs();
        run_job(1'b0, 'h200, 1, 1, 3, 0, 1'b0, -1, -1);
        chk1("P_rd_en_cycles", n_rd_en, 3);
        if (en_cyc.size() == 1) begin
            d0_at("P_col2", en_cyc[0] + 4, 16'h2020);
            d0_at("P_col3_zero", en_cyc[0] + 5, 16'h0000);
            d0_at("P_col4_zero", en_cyc[0] + 6, 16'h0000);
        end
`endif

        // randomized jobs
        for (int r = 0; r < 40; r++) begin
            run_job(1'($urandom), int'($urandom_range(0, 4095)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 14)),
                    int'($urandom_range(0, 6)), 1'($urandom), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/feature_col_feeder.md
Name: feature_col_feeder

Overview:
- Upstream stage of the vertical shift register that builds the kernel window.
- Reads feature columns from the on-chip feature buffer. Each column holds KERNEL_SIZE pixels for each of Tn input channels.
- Issues the enable pulse and streams K consecutive columns onto dia_0 or dia_1, alternating ping-pong per window.
- Waits for shift_done, then steps to the next window until a programmed window count is exhausted.

Parameters:
- Tn, 4, input channels per column word.
- KERNEL_SIZE, 5, maximum kernel size; column word holds KERNEL_SIZE pixels per channel.
- FEATURE_WIDTH, 16, bits per pixel.
- ADDR_WIDTH, 12, feature buffer address width.
- CNT_WIDTH, 10, width of window and column counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches config and begins a job when idle
- kn_size_mode  in  1  kernel mode; 0 = 5x5, 1 = 3x3; K = 5 or 3
- base_addr  in  ADDR_WIDTH  address of first column of window 0
- win_stride  in  ADDR_WIDTH  address increment between window starts
- num_windows  in  CNT_WIDTH  windows per job; 0 = empty job
- img_width  in  CNT_WIDTH  valid column count; used only with ZERO_PAD_EN
- rd_en  out  1  feature buffer read enable
- rd_addr  out  ADDR_WIDTH  feature buffer read address
- rd_data  in  Tn*KERNEL_SIZE*FEATURE_WIDTH  read data, 1-cycle latency
- enable  out  1  one-cycle window-start pulse to the shift stage
- in_select  out  1  0 = stream on dia_0, 1 = stream on dia_1
- dia_0  out  Tn*KERNEL_SIZE*FEATURE_WIDTH  column stream, path 0
- dia_1  out  Tn*KERNEL_SIZE*FEATURE_WIDTH  column stream, path 1
- shift_done  in  1  shift stage has finished the current window
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: all outputs 0; in_select 0; state IDLE; counters 0.
- Reset asserted mid-job aborts immediately. No job_done is emitted.
- FSM states:
  - IDLE: start=1 latches config, sets busy=1, in_select=0, win_idx=0, win_addr=base_addr. If num_windows==0, job_done pulses the next cycle and the FSM stays IDLE. Otherwise go to ISSUE.
  - ISSUE (1 cycle): enable=1; in_select already valid this cycle; col=0. Go to FETCH.
  - FETCH (K cycles): rd_en=1, rd_addr=win_addr+col, col increments each cycle. After the K-th read, go to WAIT.
  - WAIT: data from the last read lands. Hold until shift_done=1. Then win_idx++, win_addr+=win_stride, toggle in_select. If win_idx reaches num_windows, go to FIN; else go to ISSUE.
  - FIN (1 cycle): job_done=1, busy=0. Go to IDLE.
- Cycle timing: with enable high at cycle E, rd_en is high at cycles E+1..E+K.
- Data timing: dia_sel is registered from rd_data and carries column j at cycle E+2+j, for j=0..K-1. This matches the shift stage's capture window.
- The non-selected dia holds its last value. Neither dia changes outside the capture window.
- 3x3 mode: K=3. Column word layout is unchanged; lower lanes are used by the shift stage.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- start while busy is ignored.
- shift_done arriving before WAIT (spurious) is ignored.
- shift_done asserted at the same cycle the FSM enters WAIT counts as valid.

Optional Feature:
- Macro: FEATURE_COL_FEEDER_ZERO_PAD_EN.
- With the macro: any column whose index (win_idx*win_stride + col) is >= img_width is driven as all zeros on dia. Its read is suppressed (rd_en=0) in that cycle; timing is unchanged.
- Without the macro: img_width is unused, and all K reads are always issued.

Decomposition:
- Shared network_para package holds Tn, KERNEL_SIZE, KERNEL_SIZE_3, FEATURE_WIDTH, KERNEL_SIZE_5_MODE/KERNEL_SIZE_3_MODE, and the FSM state encoding constants.
- One natural sub-module: col_addr_gen. It owns win_addr, col, win_idx, and the pad comparison. The top keeps the FSM and the dia registers.

Test Plan:
- 5x5, base=0x010, stride=1, num_windows=2:
  - enable pulses twice, with in_select 0 then 1.
  - rd_addr reads 0x010..0x014, then 0x011..0x015.
  - dia_0 carries columns 0x010..0x014 at E+2..E+6.
  - job_done pulses one cycle after the second shift_done.
- 3x3, num_windows=1: exactly 3 rd_en cycles; dia_0 updates for 3 cycles only; dia_1 stays 0.
- shift_done delayed 20 cycles: FSM holds WAIT with rd_en=0 and dia stable; a shift_done pulse during FETCH is ignored.
- num_windows=0: job_done pulses one cycle after start, and no enable or rd_en is issued. A start while busy is ignored, checked by counting enable pulses.
- rst asserted during FETCH of window 1: all outputs are 0 next edge-free sample, and no job_done follows. A new start after release runs normally.
- With FEATURE_COL_FEEDER_ZERO_PAD_EN, img_width=3, 5x5, window 0: columns 3 and 4 are zero on dia_0, with rd_en low in those cycles.
